// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types, opcodes and select encodings for the multicycle controller
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JALR,
      S_JAL,
      S_LUI,
      S_TRAP
   } statetype;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_IMMEXT    = 2'b11;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SR   = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   // Branch resolution from funct3 and the ALU result of the compare.
   // funct3 010/011 are not branch encodings and never take.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic [31:0] alu_result);
      logic w_zero;
      w_zero = (alu_result == 32'd0);
      case (funct3)
         3'b000:  branch_taken = w_zero;
         3'b001:  branch_taken = ~w_zero;
         3'b100,
         3'b110:  branch_taken = alu_result[0];
         3'b101,
         3'b111:  branch_taken = ~alu_result[0];
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_if.sv
// rtl/mc_if.sv - controller to datapath/memory signal bundle
interface mc_if;

   logic [6:0]  Op;
   logic [2:0]  Funct3;
   logic        Funct7b5;
   logic [31:0] ALUResult;
   logic        MemReady;

   logic        MemReq;
   logic        MemWrite;
   logic        AdrSrc;
   logic        IRWrite;
   logic        PCWrite;
   logic        RegWrite;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ResultSrc;
   logic [2:0]  ImmSrc;
   logic [2:0]  ALUSelect;
   logic        SubArith;
   logic        IllegalInstr;

   // Controller side: consumes instruction fields and status, drives controls.
   modport master (
      input  Op, Funct3, Funct7b5, ALUResult, MemReady,
      output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
      output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUSelect, SubArith, IllegalInstr
   );

   // Datapath and memory side.
   modport slave (
      output Op, Funct3, Funct7b5, ALUResult, MemReady,
      input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
      input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUSelect, SubArith, IllegalInstr
   );

endinterface

// File: rtl/mc_controller_aludec.sv
// rtl/mc_controller_aludec.sv - ALU operation decode for execute and branch compare
module mc_controller_aludec
   import mc_pkg::*;
(
   input  logic [6:0] i_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_branch,
   output logic [2:0] o_alu_select,
   output logic       o_sub_arith
);

   // Branches map onto a compare; ALU ops take funct3 directly, with SLT
   // always subtracting because it needs the difference's sign.
   always_comb begin
      o_alu_select = ALU_ADD;
      o_sub_arith  = 1'b0;
      if (i_branch) begin
         case (i_funct3[2:1])
            2'b00: begin
               o_alu_select = ALU_ADD;
               o_sub_arith  = 1'b1;
            end
            2'b10: begin
               o_alu_select = ALU_SLT;
               o_sub_arith  = 1'b1;
            end
            2'b11: begin
               o_alu_select = ALU_SLTU;
               o_sub_arith  = 1'b0;
            end
            default: begin
               o_alu_select = ALU_ADD;
               o_sub_arith  = 1'b0;
            end
         endcase
      end else begin
         o_alu_select = i_funct3;
         case (i_funct3)
            ALU_SR:  o_sub_arith = i_funct7b5;
            ALU_ADD: o_sub_arith = i_funct7b5 & (i_op == OP_R);
            ALU_SLT: o_sub_arith = 1'b1;
            default: o_sub_arith = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RISC-V control FSM
module mc_controller
   import mc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   mc_if.master bus
);

   statetype    r_state;

   logic [2:0]  w_dec_alu_select;
   logic        w_dec_sub_arith;
   logic        w_taken;

   logic        w_mem_req;
   logic        w_mem_write;
   logic        w_adr_src;
   logic        w_ir_write;
   logic        w_pc_write;
   logic        w_reg_write;
   logic [1:0]  w_alu_src_a;
   logic [1:0]  w_alu_src_b;
   logic [1:0]  w_result_src;
   logic [2:0]  w_imm_src;
   logic [2:0]  w_alu_select;
   logic        w_sub_arith;
   logic        w_illegal;

   mc_controller_aludec u_aludec (
      .i_op         (bus.Op),
      .i_funct3     (bus.Funct3),
      .i_funct7b5   (bus.Funct7b5),
      .i_branch     (r_state == S_BRANCH),
      .o_alu_select (w_dec_alu_select),
      .o_sub_arith  (w_dec_sub_arith)
   );

   assign w_taken = branch_taken(bus.Funct3, bus.ALUResult);

   // State sequencing; memory states hold until MemReady, TRAP holds until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:    if (bus.MemReady) r_state <= S_DECODE;
            S_DECODE: begin
               case (bus.Op)
                  OP_LOAD,
                  OP_STORE:  r_state <= S_MEMADR;
                  OP_R:      r_state <= S_EXECR;
                  OP_I:      r_state <= S_EXECI;
                  OP_BRANCH: r_state <= S_BRANCH;
                  OP_JAL:    r_state <= S_JAL;
                  OP_JALR:   r_state <= S_JALR;
                  OP_LUI:    r_state <= S_LUI;
                  default:   r_state <= S_TRAP;
               endcase
            end
            S_MEMADR:   r_state <= (bus.Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.MemReady) r_state <= S_MEMWB;
            S_MEMWB:    r_state <= S_FETCH;
            S_MEMWRITE: if (bus.MemReady) r_state <= S_FETCH;
            S_EXECR:    r_state <= S_ALUWB;
            S_EXECI:    r_state <= S_ALUWB;
            S_ALUWB:    r_state <= S_FETCH;
            S_BRANCH:   r_state <= S_FETCH;
            S_JALR:     r_state <= S_JAL;
            S_JAL:      r_state <= S_ALUWB;
            S_LUI:      r_state <= S_FETCH;
            S_TRAP:     r_state <= S_TRAP;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   // Control decode from state; the only input-dependent enables are the
   // FETCH completion strobes and the branch-taken PC write.
   always_comb begin
      w_mem_req    = 1'b0;
      w_mem_write  = 1'b0;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src_a  = SRCA_PC;
      w_alu_src_b  = SRCB_RS2;
      w_result_src = RES_ALUOUT;
      w_imm_src    = IMM_I;
      w_alu_select = ALU_ADD;
      w_sub_arith  = 1'b0;
      w_illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req    = 1'b1;
            w_alu_src_a  = SRCA_PC;
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALURESULT;
            w_ir_write   = bus.MemReady;
            w_pc_write   = bus.MemReady;
         end
         S_DECODE: begin
            w_alu_src_a = SRCA_OLDPC;
            w_alu_src_b = SRCB_IMM;
            w_imm_src   = (bus.Op == OP_BRANCH) ? IMM_B : IMM_J;
         end
         S_MEMADR: begin
            w_alu_src_a = SRCA_RS1;
            w_alu_src_b = SRCB_IMM;
            w_imm_src   = (bus.Op == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            w_mem_req    = 1'b1;
            w_adr_src    = 1'b1;
            w_result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            w_result_src = RES_DATA;
            w_reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            w_mem_req    = 1'b1;
            w_mem_write  = 1'b1;
            w_adr_src    = 1'b1;
            w_result_src = RES_ALUOUT;
         end
         S_EXECR: begin
            w_alu_src_a  = SRCA_RS1;
            w_alu_src_b  = SRCB_RS2;
            w_alu_select = w_dec_alu_select;
            w_sub_arith  = w_dec_sub_arith;
         end
         S_EXECI: begin
            w_alu_src_a  = SRCA_RS1;
            w_alu_src_b  = SRCB_IMM;
            w_imm_src    = IMM_I;
            w_alu_select = w_dec_alu_select;
            w_sub_arith  = w_dec_sub_arith;
         end
         S_ALUWB: begin
            w_result_src = RES_ALUOUT;
            w_reg_write  = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a  = SRCA_RS1;
            w_alu_src_b  = SRCB_RS2;
            w_result_src = RES_ALUOUT;
            w_alu_select = w_dec_alu_select;
            w_sub_arith  = w_dec_sub_arith;
            w_pc_write   = w_taken;
         end
         S_JALR: begin
            w_alu_src_a = SRCA_RS1;
            w_alu_src_b = SRCB_IMM;
            w_imm_src   = IMM_I;
         end
         S_JAL: begin
            w_alu_src_a  = SRCA_OLDPC;
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALUOUT;
            w_pc_write   = 1'b1;
         end
         S_LUI: begin
            w_imm_src    = IMM_U;
            w_result_src = RES_IMMEXT;
            w_reg_write  = 1'b1;
         end
         S_TRAP: begin
            w_illegal = 1'b1;
         end
         default: begin
            w_illegal = 1'b0;
         end
      endcase
   end

   // State sits in FETCH during reset, so the enables are masked directly
   // by reset to keep the memory port quiet without waiting for a clock.
   assign bus.MemReq       = w_mem_req   & ~reset;
   assign bus.MemWrite     = w_mem_write & ~reset;
   assign bus.IRWrite      = w_ir_write  & ~reset;
   assign bus.PCWrite      = w_pc_write  & ~reset;
   assign bus.RegWrite     = w_reg_write & ~reset;
   assign bus.IllegalInstr = w_illegal   & ~reset;
   assign bus.AdrSrc       = w_adr_src;
   assign bus.ALUSrcA      = w_alu_src_a;
   assign bus.ALUSrcB      = w_alu_src_b;
   assign bus.ResultSrc    = w_result_src;
   assign bus.ImmSrc       = w_imm_src;
   assign bus.ALUSelect    = w_alu_select;
   assign bus.SubArith     = w_sub_arith;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for the multicycle controller
module tb_mc_controller;

   logic clk;
   logic reset;

   mc_if bus ();

   mc_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors;
   int checks;

   logic [19:0] exp_q[$];
   string       name_q[$];

   // Packed view of every controller output.
   logic [19:0] w_obs;
   assign w_obs = {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                   bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUSelect,
                   bus.SubArith, bus.IllegalInstr};

   // en = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite}
   function automatic logic [19:0] ov(input logic [5:0] en, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] r, input logic [2:0] imm, input logic [2:0] alu,
                                      input logic sub, input logic ill);
      return {en, a, b, r, imm, alu, sub, ill};
   endfunction

   function automatic logic [19:0] v_execi(input logic [2:0] alu, input logic sub);
      return ov(6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, alu, sub, 1'b0);
   endfunction

   function automatic logic [19:0] v_execr(input logic [2:0] alu, input logic sub);
      return ov(6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, alu, sub, 1'b0);
   endfunction

   function automatic logic [19:0] v_branch(input logic [2:0] alu, input logic sub, input logic pc);
      return ov({4'b0000, pc, 1'b0}, 2'b10, 2'b00, 2'b00, 3'b000, alu, sub, 1'b0);
   endfunction

   logic [19:0] V_RESET, V_FRDY, V_FWAIT, V_DECJ, V_DECB, V_MALW, V_MASW, V_MRD, V_MWB;
   logic [19:0] V_MWR, V_WB, V_JALR, V_JAL, V_LUI, V_TRAP;

   localparam logic [6:0] O_LOAD   = 7'b0000011;
   localparam logic [6:0] O_STORE  = 7'b0100011;
   localparam logic [6:0] O_R      = 7'b0110011;
   localparam logic [6:0] O_I      = 7'b0010011;
   localparam logic [6:0] O_BRANCH = 7'b1100011;
   localparam logic [6:0] O_JAL    = 7'b1101111;
   localparam logic [6:0] O_JALR   = 7'b1100111;
   localparam logic [6:0] O_LUI    = 7'b0110111;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle: drive inputs just after the rising edge, queue the expected
   // outputs for this cycle, then move to the next rising edge.
   task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                       input logic [31:0] res, input logic rdy, input logic [19:0] ev, input string nm);
      bus.Op        = op;
      bus.Funct3    = f3;
      bus.Funct7b5  = b5;
      bus.ALUResult = res;
      bus.MemReady  = rdy;
      exp_q.push_back(ev);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare whatever the DUT presents against the oldest expectation.
   logic [19:0] mon_ev;
   string       mon_nm;
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_ev = exp_q.pop_front();
         mon_nm = name_q.pop_front();
         checks = checks + 1;
         if (w_obs !== mon_ev) begin
            errors = errors + 1;
            $display("FAIL %s: got %05h expected %05h", mon_nm, w_obs, mon_ev);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      errors  = 0;
      checks  = 0;
      V_RESET = ov(6'b000000, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0);
      V_FRDY  = ov(6'b100110, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0);
      V_FWAIT = ov(6'b100000, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0);
      V_DECJ  = ov(6'b000000, 2'b01, 2'b01, 2'b00, 3'b011, 3'b000, 1'b0, 1'b0);
      V_DECB  = ov(6'b000000, 2'b01, 2'b01, 2'b00, 3'b010, 3'b000, 1'b0, 1'b0);
      V_MALW  = ov(6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0);
      V_MASW  = ov(6'b000000, 2'b10, 2'b01, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0);
      V_MRD   = ov(6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0);
      V_MWB   = ov(6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0);
      V_MWR   = ov(6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0);
      V_WB    = ov(6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0);
      V_JALR  = ov(6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0);
      V_JAL   = ov(6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0);
      V_LUI   = ov(6'b000001, 2'b00, 2'b00, 2'b11, 3'b100, 3'b000, 1'b0, 1'b0);
      V_TRAP  = ov(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1);

      reset = 1'b1;
      bus.Op = 7'd0; bus.Funct3 = 3'd0; bus.Funct7b5 = 1'b0; bus.ALUResult = 32'd0; bus.MemReady = 1'b0;
      @(posedge clk);
      #1;

      // Reset: MemReady is ignored, enables stay low.
      step(O_I, 3'b000, 1'b0, 32'd0, 1'b1, V_RESET, "reset_a");
      step(O_I, 3'b000, 1'b0, 32'd0, 1'b1, V_RESET, "reset_b");
      reset = 1'b0;

      // addi with MemReady tied high: RegWrite in cycle 4.
      step(O_I, 3'b000, 1'b1, 32'd0, 1'b1, V_FRDY, "addi_fetch");
      step(O_I, 3'b000, 1'b1, 32'd0, 1'b1, V_DECJ, "addi_decode");
      step(O_I, 3'b000, 1'b1, 32'd0, 1'b1, v_execi(3'b000, 1'b0), "addi_execi");
      step(O_I, 3'b000, 1'b1, 32'd0, 1'b1, V_WB, "addi_wb");

      // sub: R-type funct3 000 with b5 subtracts.
      step(O_R, 3'b000, 1'b1, 32'd0, 1'b1, V_FRDY, "sub_fetch");
      step(O_R, 3'b000, 1'b1, 32'd0, 1'b1, V_DECJ, "sub_decode");
      step(O_R, 3'b000, 1'b1, 32'd0, 1'b1, v_execr(3'b000, 1'b1), "sub_execr");
      step(O_R, 3'b000, 1'b1, 32'd0, 1'b1, V_WB, "sub_wb");

      // srai: arithmetic shift select.
      step(O_I, 3'b101, 1'b1, 32'd0, 1'b1, V_FRDY, "srai_fetch");
      step(O_I, 3'b101, 1'b1, 32'd0, 1'b1, V_DECJ, "srai_decode");
      step(O_I, 3'b101, 1'b1, 32'd0, 1'b1, v_execi(3'b101, 1'b1), "srai_execi");
      step(O_I, 3'b101, 1'b1, 32'd0, 1'b1, V_WB, "srai_wb");

      // slt: always subtracts.
      step(O_R, 3'b010, 1'b0, 32'd0, 1'b1, V_FRDY, "slt_fetch");
      step(O_R, 3'b010, 1'b0, 32'd0, 1'b1, V_DECJ, "slt_decode");
      step(O_R, 3'b010, 1'b0, 32'd0, 1'b1, v_execr(3'b010, 1'b1), "slt_execr");
      step(O_R, 3'b010, 1'b0, 32'd0, 1'b1, V_WB, "slt_wb");

      // blt taken on ALUResult[0].
      step(O_BRANCH, 3'b100, 1'b0, 32'd1, 1'b1, V_FRDY, "blt_fetch");
      step(O_BRANCH, 3'b100, 1'b0, 32'd1, 1'b1, V_DECB, "blt_decode");
      step(O_BRANCH, 3'b100, 1'b0, 32'd1, 1'b1, v_branch(3'b010, 1'b1, 1'b1), "blt_branch");

      // bgeu not taken when ALUResult[0] is set.
      step(O_BRANCH, 3'b111, 1'b0, 32'd1, 1'b1, V_FRDY, "bgeu_fetch");
      step(O_BRANCH, 3'b111, 1'b0, 32'd1, 1'b1, V_DECB, "bgeu_decode");
      step(O_BRANCH, 3'b111, 1'b0, 32'd1, 1'b1, v_branch(3'b011, 1'b0, 1'b0), "bgeu_branch");

      // beq taken on zero, bne not taken on zero.
      step(O_BRANCH, 3'b000, 1'b0, 32'd0, 1'b1, V_FRDY, "beq_fetch");
      step(O_BRANCH, 3'b000, 1'b0, 32'd0, 1'b1, V_DECB, "beq_decode");
      step(O_BRANCH, 3'b000, 1'b0, 32'd0, 1'b1, v_branch(3'b000, 1'b1, 1'b1), "beq_branch");
      step(O_BRANCH, 3'b001, 1'b0, 32'd0, 1'b1, V_FRDY, "bne_fetch");
      step(O_BRANCH, 3'b001, 1'b0, 32'd0, 1'b1, V_DECB, "bne_decode");
      step(O_BRANCH, 3'b001, 1'b0, 32'd0, 1'b1, v_branch(3'b000, 1'b1, 1'b0), "bne_branch");

      // lw with three wait cycles in MEMREAD.
      step(O_LOAD, 3'b010, 1'b0, 32'd0, 1'b1, V_FRDY, "lw_fetch");
      step(O_LOAD, 3'b010, 1'b0, 32'd0, 1'b1, V_DECJ, "lw_decode");
      step(O_LOAD, 3'b010, 1'b0, 32'd0, 1'b0, V_MALW, "lw_memadr");
      step(O_LOAD, 3'b010, 1'b0, 32'd0, 1'b0, V_MRD, "lw_memread_w1");
      step(O_LOAD, 3'b010, 1'b0, 32'd0, 1'b0, V_MRD, "lw_memread_w2");
      step(O_LOAD, 3'b010, 1'b0, 32'd0, 1'b0, V_MRD, "lw_memread_w3");
      step(O_LOAD, 3'b010, 1'b0, 32'd0, 1'b1, V_MRD, "lw_memread_rdy");
      step(O_LOAD, 3'b010, 1'b0, 32'd0, 1'b0, V_MWB, "lw_memwb");

      // sw with one fetch wait cycle.
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b0, V_FWAIT, "sw_fetch_wait");
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b1, V_FRDY, "sw_fetch");
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b1, V_DECJ, "sw_decode");
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b1, V_MASW, "sw_memadr");
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b1, V_MWR, "sw_memwrite");

      // jal.
      step(O_JAL, 3'b000, 1'b0, 32'd0, 1'b1, V_FRDY, "jal_fetch");
      step(O_JAL, 3'b000, 1'b0, 32'd0, 1'b1, V_DECJ, "jal_decode");
      step(O_JAL, 3'b000, 1'b0, 32'd0, 1'b1, V_JAL, "jal_jal");
      step(O_JAL, 3'b000, 1'b0, 32'd0, 1'b1, V_WB, "jal_wb");

      // jalr.
      step(O_JALR, 3'b000, 1'b0, 32'd0, 1'b1, V_FRDY, "jalr_fetch");
      step(O_JALR, 3'b000, 1'b0, 32'd0, 1'b1, V_DECJ, "jalr_decode");
      step(O_JALR, 3'b000, 1'b0, 32'd0, 1'b1, V_JALR, "jalr_jalr");
      step(O_JALR, 3'b000, 1'b0, 32'd0, 1'b1, V_JAL, "jalr_jal");
      step(O_JALR, 3'b000, 1'b0, 32'd0, 1'b1, V_WB, "jalr_wb");

      // lui.
      step(O_LUI, 3'b000, 1'b0, 32'd0, 1'b1, V_FRDY, "lui_fetch");
      step(O_LUI, 3'b000, 1'b0, 32'd0, 1'b1, V_DECJ, "lui_decode");
      step(O_LUI, 3'b000, 1'b0, 32'd0, 1'b1, V_LUI, "lui_lui");

      // Illegal opcode: TRAP holds with MemReady high until reset.
      step(7'b0000000, 3'b000, 1'b0, 32'd0, 1'b1, V_FRDY, "trap_fetch");
      step(7'b0000000, 3'b000, 1'b0, 32'd0, 1'b1, V_DECJ, "trap_decode");
      for (int i = 0; i < 4; i++)
         step(7'b0000000, 3'b000, 1'b0, 32'd0, 1'b1, V_TRAP, "trap_hold");
      reset = 1'b1;
      step(7'b0000000, 3'b000, 1'b0, 32'd0, 1'b1, V_RESET, "trap_reset");
      reset = 1'b0;
      step(O_LUI, 3'b000, 1'b0, 32'd0, 1'b1, V_FRDY, "post_trap_fetch");
      step(O_LUI, 3'b000, 1'b0, 32'd0, 1'b1, V_DECJ, "post_trap_decode");
      step(O_LUI, 3'b000, 1'b0, 32'd0, 1'b1, V_LUI, "post_trap_lui");

      // Reset during a MEMWRITE wait: request drops before the next clock.
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b1, V_FRDY, "swr_fetch");
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b1, V_DECJ, "swr_decode");
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b0, V_MASW, "swr_memadr");
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b0, V_MWR, "swr_memwrite_wait");
      reset = 1'b1;
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b0, V_RESET, "swr_async_reset");
      reset = 1'b0;
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b0, V_FWAIT, "swr_fetch_after_reset");
      step(O_STORE, 3'b010, 1'b0, 32'd0, 1'b1, V_FRDY, "swr_fetch_done");

      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the RISC-V integer core: the producer side of the ALU control interface. It decodes opcode/funct fields into ALU operation selects (`ALUSelect`, `SubArith`), sequences datapath mux selects and write enables across Fetch, Decode, Execute, Memory and Writeback states, and handshakes with a unified instruction/data memory port. It sits between the instruction register and the multicycle datapath (register file, ALU, PC/ALUOut/Data registers).

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `Op` in 7: opcode from instruction register.
- `Funct3` in 3: instr[14:12].
- `Funct7b5` in 1: instr[30].
- `ALUResult` in 32: combinational ALU result, used for branch resolution.
- `MemReady` in 1: memory completes current request this cycle.
- `MemReq` out 1: memory request valid.
- `MemWrite` out 1: request is a store.
- `AdrSrc` out 1: 0 = PC, 1 = Result.
- `IRWrite` out 1: load IR and OldPC.
- `PCWrite` out 1: PC <= Result.
- `RegWrite` out 1: rd <= Result.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 rs1 register.
- `ALUSrcB` out 2: 00 rs2 register, 01 ImmExt, 10 constant 4.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUSelect` out 3: ALU operation (funct3 encoding).
- `SubArith` out 1: subtract / arithmetic-shift select.
- `IllegalInstr` out 1: high while in TRAP.

## Operation
- Supported: lw, sw, R-type ALU, I-type ALU, beq/bne/blt/bge/bltu/bgeu, jal, jalr, lui. Any other opcode goes to TRAP.
- Default output in every state: `ALUSelect` = 000, `SubArith` = 0, all enables 0, all selects 0.
- ALU decode applies in EXECR and EXECI:
  - `ALUSelect` = Funct3.
  - `SubArith` = Funct7b5 for Funct3=101 (R and I).
  - `SubArith` = Funct7b5 for Funct3=000 in R-type only.
  - `SubArith` = 1 for Funct3=010. SLT needs the subtraction sum; slt/slti are forced to 1.
  - `SubArith` = 0 otherwise.
- Branch decode applies in BRANCH:
  - beq/bne: `ALUSelect` = 000, `SubArith` = 1. Taken on Zero / !Zero, where Zero = (`ALUResult` == 0).
  - blt/bge: 010, `SubArith` = 1. Taken on `ALUResult[0]` / !`ALUResult[0]`.
  - bltu/bgeu: 011, `SubArith` = 0. Same taken rule as blt/bge.
- State behaviour and transitions:
  - FETCH: `MemReq`, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ResultSrc`=10. If `MemReady`: `IRWrite`, `PCWrite`, go to DECODE. Else stay.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ImmSrc` = B for branch, J otherwise (ALUOut <= target). Next state by opcode:
    - lw/sw → MEMADR
    - R → EXECR
    - I-ALU → EXECI
    - B → BRANCH
    - jal → JAL
    - jalr → JALR
    - lui → LUI
    - other → TRAP
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc` = I for lw, S for sw. lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: `MemReq`, `AdrSrc`=1, `ResultSrc`=00. On `MemReady` → MEMWB.
  - MEMWB: `ResultSrc`=01, `RegWrite`. → FETCH.
  - MEMWRITE: `MemReq`, `MemWrite`, `AdrSrc`=1, `ResultSrc`=00. On `MemReady` → FETCH.
  - EXECR: `ALUSrcA`=10, `ALUSrcB`=00. → ALUWB.
  - EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc`=I. → ALUWB.
  - ALUWB: `ResultSrc`=00, `RegWrite`. → FETCH.
  - BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, `ResultSrc`=00, `PCWrite` = taken. → FETCH.
  - JALR: `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc`=I (ALUOut <= rs1+imm). → JAL.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=00, `PCWrite`. → ALUWB (writes OldPC+4).
  - LUI: `ImmSrc`=U, `ResultSrc`=11, `RegWrite`. → FETCH.
  - TRAP: `IllegalInstr`=1, all enables 0. Held until reset.

## Timing
- Moore outputs are decoded from state. The only Mealy terms:
  - `IRWrite`/`PCWrite` in FETCH, gated by `MemReady`.
  - `PCWrite` in BRANCH, gated by the taken condition.
- Cycle counts with zero-wait memory (`MemReady` high in the request cycle):
  - lw 5.
  - sw 4.
  - R/I 4.
  - branch 3.
  - jal 4.
  - jalr 5.
  - lui 3.
- Each wait cycle adds 1. `MemReq` stays high and all request outputs stay stable until `MemReady`.
- `MemReady` outside a request state is ignored.
- While `reset` is high:
  - State is FETCH.
  - `MemReq`, `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite`, `IllegalInstr` are forced to 0.
  - `ALUSelect` = 000, `SubArith` = 0.
- Reset asserted mid-request (FETCH/MEMREAD/MEMWRITE wait) drops `MemReq` asynchronously. The transaction is abandoned and no enable fires.
- First request is in the first clock edge after reset deassertion.

## Structure
- Shared package `mc_pkg`:
  - `statetype` enum (14 states).
  - Opcode constants: `OP_LOAD`, `OP_STORE`, `OP_R`, `OP_I`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_LUI`.
  - Select encodings for `ALUSrcA`/`ALUSrcB`/`ResultSrc`/`ImmSrc`.
  - `ALUSelect` constants (`ALU_ADD` … `ALU_AND`).
- Sub-module `aludec`: combinational Op/Funct3/Funct7b5/branch-mode → `ALUSelect`, `SubArith`. The FSM overrides its output with add in non-execute states.

## Test plan
- addi x1 = x0 + 5 (`Op`=0010011, `Funct3`=000, `Funct7b5`=1), `MemReady` tied high → `ALUSelect`=000, `SubArith`=0 in EXECI; `RegWrite` in cycle 4.
- sub (R, `Funct3`=000, `Funct7b5`=1) → `SubArith`=1 in EXECR. srai (I, 101, b5=1) → `SubArith`=1. slt (R, 010, b5=0) → `SubArith`=1.
- blt with `ALUResult`=1 → `ALUSelect`=010, `SubArith`=1, `PCWrite`=1 in BRANCH. bgeu with `ALUResult`=1 → `ALUSelect`=011, `PCWrite`=0.
- lw with `MemReady` low 3 cycles in MEMREAD → `MemReq`/`AdrSrc`=1 held 4 cycles; `RegWrite` with `ResultSrc`=01 one cycle after `MemReady`.
- `Op`=0000000 → TRAP; `IllegalInstr`=1, `MemReq`=0 indefinitely; reset returns to FETCH.
- Assert reset during MEMWRITE wait → `MemReq`/`MemWrite` drop without clock; after release, FETCH with `MemReq`=1.
